// File: rtl/sprite_feeder_pkg.sv
// rtl/sprite_feeder_pkg.sv - shared FSM state type and video timing defaults
package sprite_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } feeder_state_t;

    localparam int H_RES_DEFAULT = 640;
    localparam int V_RES_DEFAULT = 480;

endpackage

// File: rtl/sprite_feeder_if.sv
// rtl/sprite_feeder_if.sv - graphic memory request/grant/read bus
interface sprite_feeder_mem_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int WIDTH      = 8
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_grant;
    logic [WIDTH-1:0]      mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_grant,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_grant,
        output mem_data
    );
endinterface

// File: rtl/sprite_feeder_bounce_axis.sv
// rtl/sprite_feeder_bounce_axis.sv - one axis of position step with reflection at limits
module bounce_axis #(
    parameter int COORD_WIDTH = 16,
    parameter int MIN         = 0,
    parameter int MAX         = 632
) (
    input  logic signed [COORD_WIDTH-1:0] pos,
    input  logic signed [COORD_WIDTH-1:0] vel,
    output logic signed [COORD_WIDTH-1:0] next_pos,
    output logic signed [COORD_WIDTH-1:0] next_vel
);
    localparam logic signed [COORD_WIDTH:0] MIN_W = (COORD_WIDTH+1)'(MIN);
    localparam logic signed [COORD_WIDTH:0] MAX_W = (COORD_WIDTH+1)'(MAX);

    // One guard bit so a step past either limit cannot wrap before the compare.
    logic signed [COORD_WIDTH:0] sum;
    assign sum = {pos[COORD_WIDTH-1], pos} + {vel[COORD_WIDTH-1], vel};

    always_comb begin
        next_pos = sum[COORD_WIDTH-1:0];
        next_vel = vel;
        if (sum > MAX_W) begin
            next_pos = COORD_WIDTH'(MAX);
            next_vel = -vel;
        end else if (sum < MIN_W) begin
            next_pos = COORD_WIDTH'(MIN);
            next_vel = -vel;
        end
    end
endmodule

// File: rtl/sprite_feeder.sv
// rtl/sprite_feeder.sv - arms a sprite per frame, moves it, and feeds it line data in hblank
module sprite_feeder
    import sprite_feeder_pkg::*;
#(
    parameter int COORD_WIDTH = 16,
    parameter int ADDR_WIDTH  = 9,
    parameter int WIDTH       = 8,
    parameter int H_RES       = H_RES_DEFAULT,
    parameter int V_RES       = V_RES_DEFAULT,
    parameter int BASE_ADDR   = 0,
    parameter int X_INIT      = 0,
    parameter int Y_INIT      = 1,
    parameter int VX_INIT     = 1,
    parameter int VY_INIT     = 1,
    parameter int X_MAX       = 632,
    parameter int Y_MAX       = 472
) (
    input  logic                          pixel_clock,
    input  logic                          reset_n,
    input  logic signed [COORD_WIDTH-1:0] sx,
    input  logic signed [COORD_WIDTH-1:0] sy,
    input  logic                          line,
    input  logic                          frame,
    input  logic                          move_en,
    input  logic [ADDR_WIDTH-1:0]         spr_pos,
    input  logic                          spr_done,
    output logic                          start,
    output logic                          dma_avail,
    output logic signed [COORD_WIDTH-1:0] spr_x,
    output logic signed [COORD_WIDTH-1:0] spr_y,
    output logic [WIDTH-1:0]              data,
    output logic                          overrun,
    sprite_feeder_mem_if.master           mem
);
    localparam logic signed [COORD_WIDTH-1:0] H_LIMIT = COORD_WIDTH'(H_RES);
    localparam logic signed [COORD_WIDTH-1:0] V_LIMIT = COORD_WIDTH'(V_RES);
    localparam logic signed [COORD_WIDTH-1:0] ONE     = COORD_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]         BASE    = ADDR_WIDTH'(BASE_ADDR);

    feeder_state_t state, state_next;
    logic start_next;
    logic signed [COORD_WIDTH-1:0] vx, vy;
    logic signed [COORD_WIDTH-1:0] bx_pos, bx_vel, by_pos, by_vel;
    logic signed [COORD_WIDTH-1:0] y_next;
    logic move_now, arm_ok, hit_line_armed, hit_line_frame;

    bounce_axis #(.COORD_WIDTH(COORD_WIDTH), .MIN(0), .MAX(X_MAX)) u_bounce_x (
        .pos(spr_x), .vel(vx), .next_pos(bx_pos), .next_vel(bx_vel)
    );

    bounce_axis #(.COORD_WIDTH(COORD_WIDTH), .MIN(1), .MAX(Y_MAX)) u_bounce_y (
        .pos(spr_y), .vel(vy), .next_pos(by_pos), .next_vel(by_vel)
    );

    // Arming looks at the post-motion Y so a frame's decision matches where the sprite is drawn.
    assign move_now       = frame && move_en;
    assign y_next         = move_now ? by_pos : spr_y;
    assign arm_ok         = (y_next >= ONE) && (y_next < V_LIMIT);
    assign hit_line_armed = line && (sy == spr_y - ONE);
    assign hit_line_frame = line && (sy == y_next - ONE);

    always_comb begin
        state_next = state;
        start_next = 1'b0;
        case (state)
            IDLE: begin
                // spr_y==1 needs its start on the sy==0 line, which coincides with frame.
                if (frame && arm_ok) begin
                    if (hit_line_frame) begin
                        state_next = ACTIVE;
                        start_next = 1'b1;
                    end else begin
                        state_next = ARMED;
                    end
                end
            end
            ARMED: begin
                if (!frame && hit_line_armed) begin
                    state_next = ACTIVE;
                    start_next = 1'b1;
                end
            end
            ACTIVE: begin
                if (!start && spr_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            start   <= 1'b0;
            overrun <= 1'b0;
            spr_x   <= COORD_WIDTH'(X_INIT);
            spr_y   <= COORD_WIDTH'(Y_INIT);
            vx      <= COORD_WIDTH'(VX_INIT);
            vy      <= COORD_WIDTH'(VY_INIT);
        end else begin
            state <= state_next;
            start <= start_next;
            if (frame && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            if (move_now) begin
                spr_x <= bx_pos;
                vx    <= bx_vel;
                spr_y <= by_pos;
                vy    <= by_vel;
            end
        end
    end

    assign mem.mem_req  = (state == ACTIVE) && (sx >= H_LIMIT);
    assign mem.mem_addr = BASE + spr_pos;
    assign dma_avail    = mem.mem_req && mem.mem_grant;
    assign data         = mem.mem_data;
endmodule

// File: tb/tb_sprite_feeder.sv
// tb/tb_sprite_feeder.sv - directed checks of arming, clipping, DMA window, overrun, bounce and reset
module tb_sprite_feeder;
    localparam int CW = 16;
    localparam int AW = 9;
    localparam int DW = 8;

    logic pixel_clock = 1'b0;
    logic reset_n = 1'b0;
    logic signed [CW-1:0] sx = '0;
    logic signed [CW-1:0] sy = '0;
    logic line = 1'b0;
    logic frame = 1'b0;
    logic move_en = 1'b0;
    logic clip_move_en = 1'b0;
    logic [AW-1:0] spr_pos = '0;
    logic spr_done = 1'b0;

    logic start, dma_avail, overrun;
    logic signed [CW-1:0] spr_x, spr_y;
    logic [DW-1:0] data;

    logic c0_start, c0_dma, c0_overrun;
    logic signed [CW-1:0] c0_x, c0_y;
    logic [DW-1:0] c0_data;
    logic c1_start, c1_dma, c1_overrun;
    logic signed [CW-1:0] c1_x, c1_y;
    logic [DW-1:0] c1_data;

    int n_checks = 0;
    int n_fail = 0;

    sprite_feeder_mem_if #(.ADDR_WIDTH(AW), .WIDTH(DW)) mem_bus ();
    sprite_feeder_mem_if #(.ADDR_WIDTH(AW), .WIDTH(DW)) clip0_bus ();
    sprite_feeder_mem_if #(.ADDR_WIDTH(AW), .WIDTH(DW)) clip1_bus ();

    always #5 pixel_clock = ~pixel_clock;

    sprite_feeder #(
        .BASE_ADDR(100), .X_INIT(630), .Y_INIT(10), .VX_INIT(4), .VY_INIT(0)
    ) u_dut (
        .pixel_clock(pixel_clock), .reset_n(reset_n), .sx(sx), .sy(sy), .line(line),
        .frame(frame), .move_en(move_en), .spr_pos(spr_pos), .spr_done(spr_done),
        .start(start), .dma_avail(dma_avail), .spr_x(spr_x), .spr_y(spr_y),
        .data(data), .overrun(overrun), .mem(mem_bus.master)
    );

    sprite_feeder #(.Y_INIT(0), .VX_INIT(0), .VY_INIT(0)) u_clip0 (
        .pixel_clock(pixel_clock), .reset_n(reset_n), .sx(sx), .sy(sy), .line(line),
        .frame(frame), .move_en(clip_move_en), .spr_pos(spr_pos), .spr_done(spr_done),
        .start(c0_start), .dma_avail(c0_dma), .spr_x(c0_x), .spr_y(c0_y),
        .data(c0_data), .overrun(c0_overrun), .mem(clip0_bus.master)
    );

    sprite_feeder #(.Y_INIT(480), .VX_INIT(0), .VY_INIT(0)) u_clip480 (
        .pixel_clock(pixel_clock), .reset_n(reset_n), .sx(sx), .sy(sy), .line(line),
        .frame(frame), .move_en(clip_move_en), .spr_pos(spr_pos), .spr_done(spr_done),
        .start(c1_start), .dma_avail(c1_dma), .spr_x(c1_x), .spr_y(c1_y),
        .data(c1_data), .overrun(c1_overrun), .mem(clip1_bus.master)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pixel_clock);
        #1;
    endtask

    task automatic set_grant(input logic g, input logic [DW-1:0] d);
        mem_bus.mem_grant   = g;
        mem_bus.mem_data    = d;
        clip0_bus.mem_grant = g;
        clip0_bus.mem_data  = d;
        clip1_bus.mem_grant = g;
        clip1_bus.mem_data  = d;
    endtask

    task automatic frame_pulse();
        frame = 1'b1; line = 1'b1; sy = '0; sx = '0;
        step();
        frame = 1'b0; line = 1'b0;
    endtask

    initial begin
        set_grant(1'b0, 8'h00);
        step();
        step();
        chk("reset_start", start, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_mem_req", mem_bus.mem_req, 0);
        chk("reset_dma_avail", dma_avail, 0);
        chk("reset_spr_x", spr_x, 630);
        chk("reset_spr_y", spr_y, 10);
        reset_n = 1'b1;
        step();

        // Arm at frame, start exactly once after the sy==9 line.
        frame_pulse();
        chk("arm_frame_start", start, 0);
        for (int s = 1; s <= 12; s++) begin
            line = 1'b1; sy = CW'(s);
            step();
            chk($sformatf("start_after_line_sy%0d", s), start, (s == 9) ? 1 : 0);
            chk($sformatf("clip0_start_sy%0d", s), c0_start, 0);
            chk($sformatf("clip480_start_sy%0d", s), c1_start, 0);
            line = 1'b0;
            step();
            chk($sformatf("start_gap_sy%0d", s), start, 0);
        end

        // DMA window in hblank while ACTIVE.
        sx = 16'sd640; spr_pos = 9'd3; set_grant(1'b1, 8'hA5);
        #1;
        chk("hblank_mem_req", mem_bus.mem_req, 1);
        chk("hblank_mem_addr", mem_bus.mem_addr, 103);
        chk("hblank_dma_avail", dma_avail, 1);
        chk("hblank_data", data, 8'hA5);
        chk("clip0_mem_req", clip0_bus.mem_req, 0);
        chk("clip480_mem_req", clip1_bus.mem_req, 0);
        set_grant(1'b0, 8'hA5);
        #1;
        chk("nogrant_dma_avail", dma_avail, 0);
        chk("nogrant_mem_req", mem_bus.mem_req, 1);
        sx = 16'sd639;
        #1;
        chk("active_video_mem_req", mem_bus.mem_req, 0);
        sx = '0;

        // Frame while ACTIVE: overrun, no second start.
        spr_done = 1'b0;
        frame_pulse();
        chk("overrun_set", overrun, 1);
        chk("overrun_no_start", start, 0);
        line = 1'b1; sy = 16'sd9;
        step();
        chk("overrun_sy9_no_start", start, 0);
        line = 1'b0;
        spr_done = 1'b1;
        step();
        spr_done = 1'b0;
        sx = 16'sd640;
        #1;
        chk("done_idle_mem_req", mem_bus.mem_req, 0);
        sx = '0;
        frame_pulse();
        chk("rearm_frame_start", start, 0);
        line = 1'b1; sy = 16'sd9;
        step();
        chk("rearm_start", start, 1);
        line = 1'b0;
        step();
        chk("rearm_start_one_cycle", start, 0);
        chk("overrun_sticky", overrun, 1);
        chk("clip0_overrun", c0_overrun, 0);
        chk("clip480_overrun", c1_overrun, 0);

        // Asynchronous reset while ACTIVE.
        sx = 16'sd640; set_grant(1'b1, 8'h00);
        #1;
        chk("pre_reset_mem_req", mem_bus.mem_req, 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_mem_req", mem_bus.mem_req, 0);
        chk("async_reset_dma_avail", dma_avail, 0);
        step();
        reset_n = 1'b1;
        step();
        chk("post_reset_spr_x", spr_x, 630);
        chk("post_reset_spr_y", spr_y, 10);
        chk("post_reset_overrun", overrun, 0);
        sx = '0; set_grant(1'b0, 8'h00);

        // Bounce at X_MAX, then step back with reflected velocity.
        move_en = 1'b1;
        frame_pulse();
        chk("bounce_spr_x", spr_x, 632);
        chk("bounce_spr_y", spr_y, 10);
        step();
        step();
        step();
        chk("stable_spr_x", spr_x, 632);
        frame_pulse();
        chk("reflect_spr_x", spr_x, 628);
        move_en = 1'b0;
        frame_pulse();
        chk("hold_spr_x", spr_x, 628);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_feeder.md
SPRITE_FEEDER -- requirements
Module: sprite_feeder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- COORD_WIDTH, 16, signed screen coordinate width
- ADDR_WIDTH, 9, graphic memory address width
- WIDTH, 8, sprite line width in bits
- H_RES, 640, active pixels per line
- V_RES, 480, active lines
- BASE_ADDR, 0, graphic base address
- X_INIT / Y_INIT, 0 / 1, reset position
- VX_INIT / VY_INIT, 1 / 1, reset velocity, signed
- X_MAX / Y_MAX, 632 / 472, bounce limits; minimum limits are X 0, Y 1
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- pixel_clock, in, 1, pixel clock
- reset_n, in, 1, asynchronous active-low reset
- sx / sy, in, COORD_WIDTH signed, current screen position
- line, in, 1, one-cycle pulse at sx==0 of every line
- frame, in, 1, one-cycle pulse at start of every frame, coincident with line for sy==0
- move_en, in, 1, enables per-frame motion
- spr_pos, in, ADDR_WIDTH, line index from sprite
- spr_done, in, 1, sprite completion level
- mem_grant, in, 1, arbiter grant
- mem_data, in, WIDTH, memory read data, registered one cycle after mem_addr
- start, out, 1, one-cycle start pulse to sprite
- dma_avail, out, 1, memory window to sprite
- spr_x / spr_y, out, COORD_WIDTH signed, sprite position
- data, out, WIDTH, sprite line data
- mem_req, out, 1, memory request
- mem_addr, out, ADDR_WIDTH, memory address
- overrun, out, 1, sticky frame-overrun flag
REQ-003 reset_n SHALL be asynchronous and active-low; all state SHALL be clocked on pixel_clock.

Function
REQ-004 The FSM states SHALL be IDLE, ARMED and ACTIVE.
REQ-005 IDLE -> ARMED on frame, only when spr_y is in 1..V_RES-1; otherwise the FSM stays IDLE and the sprite is clipped for that frame.
REQ-006 In ARMED, on a line pulse with sy == spr_y-1, start SHALL pulse high for exactly one cycle on the following clock, and the FSM SHALL enter ACTIVE.
REQ-007 ACTIVE -> IDLE on the first cycle after the start pulse in which spr_done is 1, so a stale done from the previous frame is ignored.
REQ-008 A frame pulse while in ARMED or ACTIVE SHALL set overrun; the FSM SHALL remain in its current state and SHALL NOT issue a second start.
- Arming resumes at the first frame pulse after the return to IDLE.
- overrun clears only on reset.
REQ-009 hblank SHALL be defined as sx >= H_RES; mem_req SHALL be 1 when in ACTIVE and in hblank, combinational.
REQ-010 dma_avail SHALL equal mem_req AND mem_grant, combinational.
REQ-011 mem_addr SHALL equal BASE_ADDR + spr_pos, truncated to ADDR_WIDTH (modulo 2^ADDR_WIDTH).
REQ-012 data SHALL be mem_data passed through unregistered, so data is valid in the cycle after dma_avail (single-cycle read).
REQ-013 Motion SHALL be applied on the cycle after a frame pulse when move_en=1, before any arming for that frame takes effect.
- The update is nx = spr_x+vx and ny = spr_y+vy, computed in COORD_WIDTH+1 bits signed.
- If nx > X_MAX, spr_x SHALL become X_MAX and vx SHALL become -vx; if nx < 0, spr_x SHALL become 0 and vx SHALL become -vx; Y SHALL behave likewise with limits 1..Y_MAX.
- When move_en=0, position and velocity SHALL hold.
REQ-014 Position SHALL change only at the frame-pulse update, so spr_x and spr_y are stable for the whole frame.
REQ-015 The arming check SHALL use the spr_y value resulting from the REQ-013 update.

Reset
REQ-016 On reset: state=IDLE, start=0, overrun=0, spr_x=X_INIT, spr_y=Y_INIT, vx=VX_INIT, vy=VY_INIT.
- Combinational outputs then follow: mem_req=0, dma_avail=0.
REQ-017 A reset in the middle of ACTIVE SHALL deassert mem_req and dma_avail immediately, asynchronously; the sprite shares the same reset_n.

Structure
REQ-018 A shared package SHALL hold the FSM state enum and the H_RES/V_RES defaults, shared with the sprite and video timing blocks.
REQ-019 The bounce arithmetic SHALL be one sub-module, bounce_axis, instantiated twice (X and Y) and parameterised by MIN, MAX and COORD_WIDTH.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Y_INIT=10, move_en=0: start pulses once, one cycle after the line pulse at sy=9; no start at any other sy.
- spr_y=0 or spr_y=480: no start and no mem_req for the whole frame.
- ACTIVE, sx=640, mem_grant=1, spr_pos=3, BASE_ADDR=100: mem_addr=103, dma_avail=1; mem_grant=0 -> dma_avail=0.
- spr_done held low through the next frame pulse: overrun=1, no second start; done=1 -> IDLE, and the next frame arms normally.
- X=630, vx=+4, move_en=1, frame pulse: spr_x=632, vx=-4; next frame: spr_x=628.
- reset_n low mid-ACTIVE: mem_req=0 in the same cycle; after release, position=(X_INIT,Y_INIT) and overrun=0.
